// File: rtl/nios_debug_ocimem_pkg.sv
// Shared types and jdo field positions for the Nios II OCI RAM access controller.
package nios_debug_ocimem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_J_RD   = 3'd1,
    ST_J_CAP  = 3'd2,
    ST_J_WR   = 3'd3,
    ST_A_RD   = 3'd4,
    ST_A_DATA = 3'd5,
    ST_A_WR   = 3'd6
  } ocimem_state_e;

  typedef enum logic [1:0] {
    OP_NONE      = 2'd0,
    OP_LOAD_ADDR = 2'd1,
    OP_READ      = 2'd2,
    OP_WRITE     = 2'd3
  } jtag_op_e;

  localparam int JDO_W        = 38;
  localparam int JDO_ADDR_LSB = 17;
  localparam int JDO_DATA_MSB = 34;
  localparam int JDO_DATA_LSB = 3;
  localparam int JDO_RD_FLAG  = 35;

endpackage

// File: rtl/nios_debug_ocimem_cmd_latch.sv
// JTAG strobe decode: priority select, one-entry command holding register and
// sticky overrun flag. Address loads are reported as a one-cycle pulse.
module nios_debug_ocimem_cmd_latch
  import nios_debug_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo_i,
  input  logic              actA_i,
  input  logic              actB_i,
  input  logic              noActA_i,
  input  logic              complete_i,
  output logic              pending_o,
  output jtag_op_e          op_o,
  output logic [31:0]       data_o,
  output logic              loadAddr_o,
  output logic [ADDR_W-1:0] loadAddrVal_o,
  output logic              overrun_o
);

  logic     pending_q, pending_d;
  jtag_op_e op_q, op_d;
  logic [31:0] data_q, data_d;
  logic     overrun_q, overrun_d;
  logic     slotFree;
  logic     multiStrobe;
  logic     unusedJdoBits;

  assign unusedJdoBits = ^{jdo_i[37:36], jdo_i[2:0]};

  // The slot counts as free in the cycle its current op completes.
  assign slotFree    = !pending_q || complete_i;
  assign multiStrobe = (actB_i & noActA_i) | (actB_i & actA_i) | (noActA_i & actA_i);

  always_comb begin
    pending_d  = pending_q && !complete_i;
    op_d       = pending_d ? op_q : OP_NONE;
    data_d     = data_q;
    overrun_d  = overrun_q | multiStrobe;
    loadAddr_o = 1'b0;
    if (actB_i) begin
      if (slotFree) begin
        pending_d = 1'b1;
        op_d      = OP_WRITE;
        data_d    = jdo_i[JDO_DATA_MSB:JDO_DATA_LSB];
      end else begin
        overrun_d = 1'b1;
      end
    end else if (noActA_i) begin
      if (slotFree) begin
        pending_d = 1'b1;
        op_d      = OP_READ;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (actA_i) begin
      if (slotFree) begin
        loadAddr_o = 1'b1;
        if (jdo_i[JDO_RD_FLAG]) begin
          pending_d = 1'b1;
          op_d      = OP_READ;
        end
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= 1'b0;
      op_q      <= OP_NONE;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      op_q      <= op_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending_o     = pending_q;
  assign op_o          = op_q;
  assign data_o        = data_q;
  assign loadAddrVal_o = jdo_i[JDO_ADDR_LSB +: ADDR_W];
  assign overrun_o     = overrun_q;

endmodule

// File: rtl/nios_debug_ocimem_arbiter.sv
// Single-port OCI RAM controller: arbitrates JTAG commands against Avalon-MM
// requests, sequences the RAM read latency and keeps MonAReg/MonDReg.
module nios_debug_ocimem_arbiter
  import nios_debug_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wren,
  output logic [3:0]        ram_byteenable,
  output logic [31:0]       ram_wrdata,
  input  logic [31:0]       ram_rddata,
  output logic [ADDR_W-1:0] MonAReg,
  output logic [31:0]       MonDReg,
  output logic              cmd_overrun
);

  ocimem_state_e     state_q, state_d;
  logic              lastJtag_q, lastJtag_d;
  logic [ADDR_W-1:0] monA_q, monA_d;
  logic [31:0]       monD_q, monD_d;
  logic [31:0]       readData_q;
  logic [ADDR_W-1:0] ramAddr_q;
  logic              cmdPending;
  jtag_op_e          cmdOp;
  logic [31:0]       cmdData;
  logic              loadAddr;
  logic [ADDR_W-1:0] loadAddrVal;
  logic              jtagDone;
  logic              avsReq;

  assign jtagDone = (state_q == ST_J_CAP) || (state_q == ST_J_WR);
  assign avsReq   = avs_read || avs_write;

  nios_debug_ocimem_cmd_latch #(.ADDR_W(ADDR_W)) u_cmdLatch (
    .clk           (clk),
    .reset         (reset),
    .jdo_i         (jdo),
    .actA_i        (take_action_ocimem_a),
    .actB_i        (take_action_ocimem_b),
    .noActA_i      (take_no_action_ocimem_a),
    .complete_i    (jtagDone),
    .pending_o     (cmdPending),
    .op_o          (cmdOp),
    .data_o        (cmdData),
    .loadAddr_o    (loadAddr),
    .loadAddrVal_o (loadAddrVal),
    .overrun_o     (cmd_overrun)
  );

  // JTAG normally wins; after a JTAG grant a waiting Avalon master goes next.
  always_comb begin
    state_d    = state_q;
    lastJtag_d = lastJtag_q;
    case (state_q)
      ST_IDLE: begin
        if (cmdPending && !(lastJtag_q && avsReq)) begin
          lastJtag_d = 1'b1;
          state_d    = (cmdOp == OP_WRITE) ? ST_J_WR : ST_J_RD;
        end else if (avsReq) begin
          lastJtag_d = 1'b0;
          state_d    = avs_write ? ST_A_WR : ST_A_RD;
        end
      end
      ST_J_RD: state_d = ST_J_CAP;
      ST_A_RD: state_d = ST_A_DATA;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      ST_J_RD, ST_J_WR: ram_address = monA_q;
      ST_A_RD, ST_A_WR: ram_address = avs_address;
      default:          ram_address = ramAddr_q;
    endcase
    ram_wren        = (state_q == ST_J_WR) || (state_q == ST_A_WR);
    ram_byteenable  = (state_q == ST_A_WR) ? avs_byteenable : 4'hF;
    ram_wrdata      = (state_q == ST_J_WR) ? cmdData : avs_writedata;
    avs_waitrequest = !((state_q == ST_A_DATA) || (state_q == ST_A_WR));
    avs_readdata    = (state_q == ST_A_DATA) ? ram_rddata : readData_q;
  end

  // A fresh address load overrides the post-op increment when both coincide.
  always_comb begin
    monA_d = monA_q;
    if (loadAddr) begin
      monA_d = loadAddrVal;
    end else if (jtagDone) begin
      monA_d = monA_q + 1'b1;
    end
    monD_d = (state_q == ST_J_CAP) ? ram_rddata : monD_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lastJtag_q <= 1'b0;
      monA_q     <= '0;
      monD_q     <= '0;
      readData_q <= '0;
      ramAddr_q  <= '0;
    end else begin
      state_q    <= state_d;
      lastJtag_q <= lastJtag_d;
      monA_q     <= monA_d;
      monD_q     <= monD_d;
      readData_q <= avs_readdata;
      ramAddr_q  <= ram_address;
    end
  end

  assign MonAReg = monA_q;
  assign MonDReg = monD_q;

endmodule
